// File: rtl/risc_alu_pkg.sv
// Shared types for the multi-cycle EX-stage ALU: opcode and FSM state encodings
// plus opcode classification helpers.
package risc_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_SLL   = 4'b0100,
        ALU_SRL   = 4'b0101,
        ALU_XOR   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_MUL   = 4'b1010,
        ALU_MULHU = 4'b1011,
        ALU_DIVU  = 4'b1100,
        ALU_REMU  = 4'b1101,
        ALU_DIV   = 4'b1110,
        ALU_REM   = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    // 1010..1111 run through the iterative engine
    function automatic logic is_multicycle(alu_op_e op);
        return op[3] && (op[2] || op[1]);
    endfunction

    function automatic logic is_divide(alu_op_e op);
        return op[3] && op[2];
    endfunction

endpackage

// File: rtl/risc_alu_if.sv
// Operand/result handshake bundle between the pipeline (master) and the ALU (slave).
interface risc_alu_if #(
    parameter int XLEN = 32
);
    import risc_alu_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] operandA;
    logic [XLEN-1:0] operandB;
    alu_op_e         alu_op;
    logic            out_valid;
    logic [XLEN-1:0] alu_out;
    logic            zero;
    logic            busy;

    modport master (
        output flush, in_valid, operandA, operandB, alu_op,
        input  in_ready, out_valid, alu_out, zero, busy
    );

    modport slave (
        input  flush, in_valid, operandA, operandB, alu_op,
        output in_ready, out_valid, alu_out, zero, busy
    );

endinterface

// File: rtl/risc_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Optional signed DIV/REM when RISC_ALU_SIGNED_DIV_EN is defined.
module risc_alu_muldiv
    import risc_alu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(XLEN - 1);
    localparam logic [SHW:0] CNT_FULL = (SHW+1)'(XLEN);

    logic [SHW:0]    count_reg;
    logic            run_reg;
    logic            is_div_reg;
    alu_op_e         op_reg;
    logic [XLEN-1:0] acc_reg;   // product high half / partial remainder
    logic [XLEN-1:0] lsr_reg;   // multiplier shifting out / quotient shifting in
    logic [XLEN-1:0] opb_reg;   // multiplicand / divisor magnitude

    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] load_lsr, load_opb;
    logic            load_div;

`ifdef RISC_ALU_SIGNED_DIV_EN
    logic neg_q_reg, neg_r_reg;
    logic sgn_op, a_neg, b_neg;

    always_comb begin
        sgn_op = (op == ALU_DIV) || (op == ALU_REM);
        a_neg  = sgn_op && a[XLEN-1];
        b_neg  = sgn_op && b[XLEN-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    always_comb begin
        load_div = is_divide(op);
        load_lsr = load_div ? a_mag : b;
        load_opb = load_div ? b_mag : a;
    end

    // One iteration step; on start it operates on the freshly loaded operands
    // so that XLEN steps complete one cycle before the result is consumed.
    logic [XLEN-1:0] src_acc, src_lsr, src_opb;
    logic            src_div;
    logic [XLEN:0]   mul_sum, div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] step_acc, step_lsr;

    always_comb begin
        src_acc   = start ? '0 : acc_reg;
        src_lsr   = start ? load_lsr : lsr_reg;
        src_opb   = start ? load_opb : opb_reg;
        src_div   = start ? load_div : is_div_reg;
        mul_sum   = {1'b0, src_acc} + (src_lsr[0] ? {1'b0, src_opb} : '0);
        div_shift = {src_acc, src_lsr[XLEN-1]};
        div_ge    = div_shift >= {1'b0, src_opb};
        div_diff  = div_shift[XLEN-1:0] - src_opb;
        if (src_div) begin
            step_acc = div_ge ? div_diff : div_shift[XLEN-1:0];
            step_lsr = {src_lsr[XLEN-2:0], div_ge};
        end else begin
            step_acc = mul_sum[XLEN:1];
            step_lsr = {mul_sum[0], src_lsr[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            run_reg    <= 1'b0;
            count_reg  <= '0;
            is_div_reg <= 1'b0;
            op_reg     <= ALU_MUL;
            acc_reg    <= '0;
            lsr_reg    <= '0;
            opb_reg    <= '0;
`ifdef RISC_ALU_SIGNED_DIV_EN
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
`endif
        end else if (start) begin
            run_reg    <= 1'b1;
            count_reg  <= CNT_ONE;
            is_div_reg <= load_div;
            op_reg     <= op;
            acc_reg    <= step_acc;
            lsr_reg    <= step_lsr;
            opb_reg    <= load_opb;
`ifdef RISC_ALU_SIGNED_DIV_EN
            // a zero divisor keeps the all-ones quotient regardless of signs
            neg_q_reg  <= (a_neg ^ b_neg) && (b != '0);
            neg_r_reg  <= a_neg;
`endif
        end else if (run_reg) begin
            if (count_reg == CNT_FULL) begin
                run_reg   <= 1'b0;
                count_reg <= '0;
            end else begin
                acc_reg   <= step_acc;
                lsr_reg   <= step_lsr;
                count_reg <= count_reg + CNT_ONE;
            end
        end
    end

    // Final step happens at the coming edge; result is valid in the cycle after.
    assign done = run_reg && (count_reg == CNT_LAST);

    logic [XLEN-1:0] quo, rem;

    always_comb begin
        quo = lsr_reg;
        rem = acc_reg;
`ifdef RISC_ALU_SIGNED_DIV_EN
        if (neg_q_reg) quo = -lsr_reg;
        if (neg_r_reg) rem = -acc_reg;
`endif
        case (op_reg)
            ALU_MUL:            result = lsr_reg;
            ALU_MULHU:          result = acc_reg;
            ALU_DIVU, ALU_DIV:  result = quo;
            ALU_REMU, ALU_REM:  result = rem;
            default:            result = '0;
        endcase
    end

endmodule

// File: rtl/risc_alu_mc.sv
// Registered EX-stage ALU with valid/ready input and iterative mul/div.
// Signed DIV/REM are enabled by defining RISC_ALU_SIGNED_DIV_EN.
module risc_alu_mc
    import risc_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    risc_alu_if.slave  bus
);

    localparam int SHW = $clog2(XLEN);

    state_e          state_reg;
    logic            in_ready_reg;
    logic            busy_reg;
    logic            out_valid_reg;
    logic [XLEN-1:0] alu_out_reg;
    logic            zero_reg;
    logic            zero_pend_reg;

    logic            accept;
    logic            start_mc;
    logic            operands_eq;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sc_result;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    assign accept      = bus.in_valid && in_ready_reg && !bus.flush;
    assign start_mc    = accept && is_multicycle(bus.alu_op);
    assign operands_eq = (bus.operandA == bus.operandB);
    assign shamt       = bus.operandB[SHW-1:0];

    always_comb begin
        sc_result = '0;
        case (bus.alu_op)
            ALU_ADD:  sc_result = bus.operandA + bus.operandB;
            ALU_SUB:  sc_result = bus.operandA - bus.operandB;
            ALU_AND:  sc_result = bus.operandA & bus.operandB;
            ALU_OR:   sc_result = bus.operandA | bus.operandB;
            ALU_SLL:  sc_result = bus.operandA << shamt;
            ALU_SRL:  sc_result = bus.operandA >> shamt;
            ALU_XOR:  sc_result = bus.operandA ^ bus.operandB;
            ALU_SRA:  sc_result = XLEN'($signed(bus.operandA) >>> shamt);
            ALU_SLT:  sc_result = {{(XLEN-1){1'b0}},
                                   $signed(bus.operandA) < $signed(bus.operandB)};
            ALU_SLTU: sc_result = {{(XLEN-1){1'b0}}, bus.operandA < bus.operandB};
            default:  sc_result = '0;
        endcase
    end

    risc_alu_muldiv #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .flush  (bus.flush),
        .start  (start_mc),
        .op     (bus.alu_op),
        .a      (bus.operandA),
        .b      (bus.operandB),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            alu_out_reg   <= '0;
            zero_reg      <= 1'b0;
            zero_pend_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (bus.flush) begin
                // alu_out/zero keep their last delivered value
                state_reg    <= IDLE;
                in_ready_reg <= 1'b1;
                busy_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_mc) begin
                            state_reg     <= CALC;
                            in_ready_reg  <= 1'b0;
                            busy_reg      <= 1'b1;
                            zero_pend_reg <= operands_eq;
                        end else if (accept) begin
                            alu_out_reg   <= sc_result;
                            zero_reg      <= operands_eq;
                            out_valid_reg <= 1'b1;
                        end
                    end
                    CALC: begin
                        if (md_done) state_reg <= FIN;
                    end
                    FIN: begin
                        alu_out_reg   <= md_result;
                        zero_reg      <= zero_pend_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= IDLE;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.busy      = busy_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.alu_out   = alu_out_reg;
    assign bus.zero      = zero_reg;

endmodule

// File: doc/risc_alu_mc.md
Name: risc_alu_mc

Overview:
- Parametrised, registered successor to the pipeline's combinational ALU, sitting in the EX stage.
- Adds XOR/SRA/SLT/SLTU and iterative multiply/divide/remainder.
- Uses a valid/ready input handshake; the hazard unit stalls the pipeline on in_ready=0.
- All results are registered. Single-cycle ops take 1 cycle; mul/div ops take XLEN+1 cycles.

Parameters:
XLEN, 32, operand/result width; power of two, 8..64
SHW, $clog2(XLEN), shift-amount width taken from operandB[SHW-1:0] (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  abort any in-flight op; drop the same-cycle input
in_valid  in  1  operands/op present
in_ready  out  1  ALU can accept (state IDLE)
operandA  in  XLEN  first operand / dividend / multiplicand
operandB  in  XLEN  second operand / divisor / multiplier / shift amount
alu_op  in  4  operation code (see Behaviour)
out_valid  out  1  one-cycle pulse: alu_out/zero valid
alu_out  out  XLEN  result, held until next result
zero  out  1  registered (operandA==operandB) of the accepted op
busy  out  1  multi-cycle op in progress

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE, in_ready=1 after reset deasserts, out_valid=0, alu_out=0, zero=0, busy=0, counter=0. Reset mid-op abandons the op silently; no out_valid.
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SRL (low 6 encodings match the previous ALU), 0110 XOR, 0111 SRA, 1000 SLT (signed, 1/0 zero-extended), 1001 SLTU, 1010 MUL (low XLEN), 1011 MULHU (high XLEN, unsigned), 1100 DIVU, 1101 REMU, 1110 DIV, 1111 REM.
- Accept = in_valid & in_ready & !flush.
- Single-cycle op accepted at edge N: out_valid=1 during cycle N+1. Back-to-back acceptance every cycle is allowed.
- Multi-cycle op accepted at edge N:
  - state IDLE->CALC, busy=1, in_ready=0.
  - XLEN iterations: shift-add for MUL/MULHU, restoring divide for DIV*/REM*.
  - Then FIN for 1 cycle (sign fixup, result select); out_valid=1 in cycle N+XLEN+1. State returns to IDLE with in_ready=1 in that same cycle.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. Shifts use only operandB[SHW-1:0]. SRA replicates operandA[XLEN-1].
- Divide by zero: quotient=all ones, remainder=dividend, full latency, no exception.
- Signed overflow (DIV of most-negative by -1): quotient=most-negative, remainder=0.
- zero is computed on the accepted operands and registered alongside alu_out.
- flush in any state: next state IDLE, busy=0, out_valid=0, counter cleared, alu_out unchanged. flush and in_valid in the same cycle: flush wins, input dropped.
- out_valid must never assert without a matching prior acceptance. Exactly one pulse per accepted, unflushed op.

Optional Feature:
Macro RISC_ALU_SIGNED_DIV_EN.
- Defined: DIV/REM (1110/1111) perform signed division: operands are negated to magnitude first; quotient sign=signA^signB; remainder sign=signA.
- Undefined: 1110/1111 decode as DIVU/REMU with identical latency; the sign-fixup logic is not built.

Decomposition:
- Package risc_alu_pkg:
  - alu_op_e enum (4-bit, encodings above)
  - state enum IDLE/CALC/FIN
  - function is_multicycle(alu_op_e)
- Sub-module risc_alu_muldiv: iterative engine with start/flush inputs and done/result outputs, its own counter (SHW+1 bits) and accumulator/remainder registers.
- The top holds the single-cycle datapath, the handshake and the output registers.

Test Plan (XLEN=32):
- ADD 5,7 then SUB 5,5 on consecutive cycles -> two consecutive out_valid pulses: 12 with zero=0, then 0 with zero=1; in_ready stays 1.
- MULHU 0xFFFFFFFF,0xFFFFFFFF -> in_ready=0 for 32 cycles; out_valid 33 cycles after accept with 0xFFFFFFFE. MUL same operands -> 0x00000001.
- DIVU 100,0 -> 0xFFFFFFFF; REMU 100,0 -> 100; DIVU 100,7 -> 14; REMU 100,7 -> 2.
- Macro defined: DIV -7,2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIV 0x80000000,-1 -> 0x80000000. Macro undefined: DIV 0xFFFFFFF9,2 -> 0x7FFFFFFC.
- Flush at iteration 10 of DIVU -> no out_valid, in_ready=1 next cycle; an ADD 1,1 issued the next cycle returns 2.
- rst asserted mid-MUL -> all outputs 0 at the next edge; no out_valid; SRA 0x80000000,4 afterwards -> 0xF8000000.
